// File: rtl/s_term_cfg_switch_matrix_pkg.sv
// Shared types and helpers for the south-terminal configurable switch matrix.
// Per-channel configuration is {reg_en, sel[1:0]}.
package s_term_sm_pkg;

    localparam int SEL_W     = 2;
    localparam int CH_CFG_W  = SEL_W + 1;

    typedef enum logic [SEL_W-1:0] {
        SEL_LEGACY = 2'd0,
        SEL_S4ALT  = 2'd1,
        SEL_GND    = 2'd2,
        SEL_VCC    = 2'd3
    } sel_e;

    function automatic int cfg_w(input int n_uio);
        return n_uio * CH_CFG_W;
    endfunction

endpackage

// File: rtl/s_term_cfg_switch_matrix_if.sv
// Serial configuration chain bundle: shift/commit requests in, chain tap and status out.
interface s_term_cfg_switch_matrix_if;

    logic cfg_shift_en;
    logic cfg_data_in;
    logic cfg_commit;
    logic cfg_data_out;
    logic cfg_full;
    logic cfg_err;

    modport master (
        output cfg_shift_en,
        output cfg_data_in,
        output cfg_commit,
        input  cfg_data_out,
        input  cfg_full,
        input  cfg_err
    );

    modport slave (
        input  cfg_shift_en,
        input  cfg_data_in,
        input  cfg_commit,
        output cfg_data_out,
        output cfg_full,
        output cfg_err
    );

endinterface

// File: rtl/s_term_cfg_switch_matrix_out_cell.sv
// One UIO_BOT_FIN channel: 4:1 source mux followed by an always-clocking flop
// that can be bypassed for a zero-latency path.
module s_term_sm_out_cell
    import s_term_sm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel,
    input  logic             reg_en,
    input  logic             src_legacy,
    input  logic             src_alt,
    output logic             fin
);

    logic mux_p0;
    logic fin_p1;

    always_comb begin
        mux_p0 = 1'b0;
        case (sel_e'(sel))
            SEL_LEGACY: mux_p0 = src_legacy;
            SEL_S4ALT:  mux_p0 = src_alt;
            SEL_GND:    mux_p0 = 1'b0;
            SEL_VCC:    mux_p0 = 1'b1;
        endcase
    end

    // p0 -> p1: registered copy of the mux, kept running so reg_en can flip freely
    always_ff @(posedge clk) begin
        if (reset) begin
            fin_p1 <= 1'b0;
        end else begin
            fin_p1 <= mux_p0;
        end
    end

    assign fin = reg_en ? fin_p1 : mux_p0;

endmodule

// File: rtl/s_term_cfg_switch_matrix.sv
// South-terminal switch matrix: fixed N-bound loopback plus configurable UIO_BOT_FIN
// sources loaded through a serial shadow chain and committed atomically.
module s_term_cfg_switch_matrix
    import s_term_sm_pkg::*;
#(
    parameter int N_S1  = 4,
    parameter int N_S2  = 8,
    parameter int N_S4  = 16,
    parameter int N_UIO = 20
) (
    input  logic             UserCLK,
    input  logic             reset,

    input  logic [N_S1-1:0]  S1END,
    input  logic [N_S2-1:0]  S2MID,
    input  logic [N_S2-1:0]  S2END,
    input  logic [N_S4-1:0]  S4END,
    input  logic [N_S4-1:0]  SS4END,
    input  logic [N_UIO-1:0] UIO_BOT_FOUT,

    output logic [N_S1-1:0]  N1BEG,
    output logic [N_S2-1:0]  N2BEG,
    output logic [N_S2-1:0]  N2BEGb,
    output logic [N_S4-1:0]  N4BEG,
    output logic [N_S4-1:0]  NN4BEG,
    output logic             Co0,
    output logic [N_UIO-1:0] UIO_BOT_FIN,

    s_term_cfg_switch_matrix_if.slave cfg
);

    localparam int CFG_W = cfg_w(N_UIO);
    localparam int CNT_W = $clog2(CFG_W + 1);

    if (N_UIO < N_S4 || N_UIO > 2 * N_S4) begin : g_range_err
        $error("s_term_cfg_switch_matrix: N_UIO must lie in [N_S4, 2*N_S4]");
    end

    // Fixed N-bound loopback, bit-reversed within each bundle
    for (genvar k = 0; k < N_S1; k++) begin : g_n1
        assign N1BEG[k] = S1END[N_S1-1-k];
    end

    for (genvar k = 0; k < N_S2; k++) begin : g_n2
        assign N2BEG[k]  = S2MID[N_S2-1-k];
        assign N2BEGb[k] = S2END[N_S2-1-k];
    end

    for (genvar k = 0; k < N_S4; k++) begin : g_n4
        assign N4BEG[k] = UIO_BOT_FOUT[N_S4-1-k];
        if (k < N_UIO - N_S4) begin : g_uio
            assign NN4BEG[k] = UIO_BOT_FOUT[N_UIO-1-k];
        end else begin : g_s4
            assign NN4BEG[k] = S4END[N_S4-1-k];
        end
    end

    assign Co0 = 1'b0;

    logic [CFG_W-1:0] shadow;
    logic [CFG_W-1:0] active;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             full;
    logic             commit_ok;

    assign full      = (cnt == CNT_W'(CFG_W));
    assign commit_ok = cfg.cfg_commit && full;

    // Commit takes the pre-shift shadow; a shift in the same cycle starts the next load at one bit
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            err <= cfg.cfg_commit && !full;
            if (cfg.cfg_shift_en) begin
                shadow <= {shadow[CFG_W-2:0], cfg.cfg_data_in};
            end
            if (commit_ok) begin
                active <= shadow;
                cnt    <= cfg.cfg_shift_en ? CNT_W'(1) : '0;
            end else if (cfg.cfg_shift_en && !full) begin
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

    assign cfg.cfg_data_out = shadow[CFG_W-1];
    assign cfg.cfg_full     = full;
    assign cfg.cfg_err      = err;

    // All-zero configuration selects the legacy wiring on every channel
    for (genvar j = 0; j < N_UIO; j++) begin : g_ch
        logic src_legacy;
        logic src_alt;

        if (j < N_S4) begin : g_leg_ss4
            assign src_legacy = SS4END[N_S4-1-j];
        end else begin : g_leg_s4
            assign src_legacy = S4END[N_UIO-1-j];
        end

        assign src_alt = S4END[N_S4-1-(j % N_S4)];

        s_term_sm_out_cell u_cell (
            .clk        (UserCLK),
            .reset      (reset),
            .sel        (active[CH_CFG_W*j +: SEL_W]),
            .reg_en     (active[CH_CFG_W*j + SEL_W]),
            .src_legacy (src_legacy),
            .src_alt    (src_alt),
            .fin        (UIO_BOT_FIN[j])
        );
    end

endmodule
